pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//   Pipeline sequencer for the 5-stage core. Drives per-stage stall/flush to pc_reg, if_id, id_ex, ex_mem, mem_wb.
//   Merges ID load-use, EX multi-cycle (div/madd) and MEM wait requests, and runs exception flush with a redirect PC.
//   Keeps a saturating stall-cycle performance counter.
// PARAMETERS
//   CNT_W      6   width of multi-cycle op length and down-counter
//   FLUSH_LEN  1   cycles flush stays asserted per exception (>=1)
// PORTS
//   clk           in   1        core clock
//   rst           in   1        synchronous reset, active-high (`RstEnable)
//   stallreq_id   in   1        level: ID load-use hazard this cycle
//   ex_mc_start   in   1        pulse: EX issues a multi-cycle op this cycle
//   ex_mc_cycles  in   CNT_W    extra EX cycles of that op, sampled with ex_mc_start
//   stallreq_mem  in   1        level: data memory not ready this cycle
//   excp_req      in   1        pulse: exception detected in MEM
//   excp_vector   in   32       handler address, sampled with excp_req
//   stall         out  6        [0]pc [1]if [2]id [3]ex [4]mem [5]wb; 1 = hold
//   flush         out  1        clear all pipeline registers to `ZeroWord
//   new_pc        out  32       redirect PC, valid while flush=1
//   excp_ack      out  1        excp_req accepted this cycle
//   mc_done       out  1        last cycle of EX multi-cycle op
//   perf_stall    out  32       cycles with stall[0]=1, saturating
// BEHAVIOUR
//   Reset (rst=1 at posedge): state RUN, counter 0, new_pc 0, perf_stall 0.
//     While rst=1, stall=0, flush=0, excp_ack=0, mc_done=0.
//   FSM states RUN, MC, FLUSH. State, counter, new_pc and perf_stall are registered.
//     stall, flush, excp_ack and mc_done decode combinationally from state and current inputs (same-cycle effect).
//   Stall vectors: id=6'b000111, ex=6'b001111, mem=6'b011111. Active vectors are ORed.
//   RUN:
//     excp_req -> excp_ack=1, latch excp_vector, cnt<=FLUSH_LEN-1, next FLUSH.
//       Overrides ex_mc_start in the same cycle.
//     else ex_mc_start and ex_mc_cycles!=0 -> cnt<=ex_mc_cycles, next MC.
//       ex_mc_cycles==0 is a single-cycle op: no stall, no mc_done.
//     stall = (stallreq_id?id:0) | (stallreq_mem?mem:0).
//   MC:
//     stall includes ex every cycle. cnt decrements by 1 per cycle, frozen while stallreq_mem=1.
//     cnt==1 and !stallreq_mem -> mc_done=1, next RUN. EX stall is still held this cycle and released the cycle after.
//     ex_mc_start is ignored (EX is frozen).
//     excp_req -> abort: excp_ack=1, cnt reloaded for flush, mc_done never pulses, next FLUSH.
//   FLUSH:
//     flush=1, new_pc=latched vector, stall=0. excp_req ignored, excp_ack=0.
//     cnt==0 -> next RUN; else cnt decrements.
//   perf_stall: +1 on every non-reset cycle with stall[0]=1. Holds at 32'hFFFF_FFFF.
//   Latency: stall/flush act the same cycle as their request; redirect PC is fetched the cycle after flush deasserts.
// STRUCTURE
//   inc/defines.v gains: `StallNone/`StallId/`StallEx/`StallMem 6-bit vectors,
//     `CtrlRun/`CtrlMc/`CtrlFlush 2-bit state codes, `ExcpVecWidth.
//   Sub-module ctrl_sat_cnt (32-bit saturating counter: clk, rst, inc, q) holds perf_stall.
//   FSM and the stall decode stay in pipe_ctrl.
// TESTING
//   stallreq_id=1 for 2 cycles in RUN -> stall=6'b000111 both cycles, perf_stall=2.
//   ex_mc_start, ex_mc_cycles=4 -> stall=6'b001111 for 4 cycles, mc_done on 4th, stall=0 on 5th.
//   MC with cnt=3, stallreq_mem=1 for 2 cycles -> stall=6'b011111, cnt holds 3; mc_done 3 cycles after mem releases.
//   excp_req with vector 32'h0000_0100 during MC -> excp_ack=1, then flush=1 and new_pc=0x100 for FLUSH_LEN cycles; no mc_done.
//   excp_req and ex_mc_start in the same RUN cycle -> FLUSH wins, no MC entry. Second excp_req during FLUSH -> excp_ack=0.
//   rst=1 mid-MC -> next cycle all outputs 0, state RUN. perf_stall forced to 32'hFFFF_FFFE plus 3 stall cycles -> reads 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// Stall vectors are indexed [0]pc [1]if [2]id [3]ex [4]mem [5]wb.
package pipe_ctrl_pkg;

  localparam int EXCP_VEC_W = 32;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_MC    = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  function automatic logic [5:0] stall_vec(
    input logic id,
    input logic ex,
    input logic mem
  );
    logic [5:0] v;
    v = STALL_NONE;
    if (id)  v = v | STALL_ID;
    if (ex)  v = v | STALL_EX;
    if (mem) v = v | STALL_MEM;
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// 32-bit saturating event counter.
// Sticks at all-ones instead of wrapping.
module ctrl_sat_cnt #(
  parameter logic [31:0] RST_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (inc && (q != 32'hFFFF_FFFF)) begin
      q <= q + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, sequences
// multi-cycle EX ops and runs exception flush/redirect.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          CNT_W     = 6,
  parameter int          FLUSH_LEN = 1,
  parameter logic [31:0] PERF_RST  = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stallreq_id,
  input  logic                  ex_mc_start,
  input  logic [CNT_W-1:0]      ex_mc_cycles,
  input  logic                  stallreq_mem,
  input  logic                  excp_req,
  input  logic [EXCP_VEC_W-1:0] excp_vector,
  output logic [5:0]            stall,
  output logic                  flush,
  output logic [EXCP_VEC_W-1:0] new_pc,
  output logic                  excp_ack,
  output logic                  mc_done,
  output logic [31:0]           perf_stall
);

  localparam logic [CNT_W-1:0] FL_RELOAD = CNT_W'(FLUSH_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [EXCP_VEC_W-1:0]   pc_q, pc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    unique case (state_q)
      ST_RUN: begin
        if (excp_req) begin
          state_d = ST_FLUSH;
          cnt_d   = FL_RELOAD;
          pc_d    = excp_vector;
        end else if (ex_mc_start && (ex_mc_cycles != '0)) begin
          state_d = ST_MC;
          cnt_d   = ex_mc_cycles;
        end
      end
      ST_MC: begin
        if (excp_req) begin
          state_d = ST_FLUSH;
          cnt_d   = FL_RELOAD;
          pc_d    = excp_vector;
        end else if (!stallreq_mem) begin
          // memory wait freezes EX, so the op count freezes too
          if (cnt_q <= CNT_ONE) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall    = STALL_NONE;
    flush    = 1'b0;
    excp_ack = 1'b0;
    mc_done  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_RUN: begin
          stall    = stall_vec(stallreq_id, 1'b0,
                               stallreq_mem);
          excp_ack = excp_req;
        end
        ST_MC: begin
          stall    = stall_vec(stallreq_id, 1'b1,
                               stallreq_mem);
          excp_ack = excp_req;
          mc_done  = (cnt_q == CNT_ONE)
                   && !stallreq_mem
                   && !excp_req;
        end
        ST_FLUSH: begin
          flush = 1'b1;
        end
        default: begin
          flush = 1'b0;
        end
      endcase
    end
  end

  assign new_pc = pc_q;

  ctrl_sat_cnt #(
    .RST_VAL (PERF_RST)
  ) u_perf (
    .clk (clk),
    .rst (rst),
    .inc (stall[0]),
    .q   (perf_stall)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios
// plus randomized traffic against a cycle-level model.
module tb_pipe_ctrl;

  localparam int CW = 6;
  localparam int FL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          stallreq_id;
  logic          ex_mc_start;
  logic [CW-1:0] ex_mc_cycles;
  logic          stallreq_mem;
  logic          excp_req;
  logic [31:0]   excp_vector;

  logic [5:0]    stall, stall2;
  logic          flush, flush2;
  logic [31:0]   new_pc, new_pc2;
  logic          excp_ack, excp_ack2;
  logic          mc_done, mc_done2;
  logic [31:0]   perf_stall, perf_stall2;

  int n_chk  = 0;
  int n_pass = 0;

  int          busy;
  int          fl_left;
  logic [31:0] m_pc;
  longint      m_perf;
  longint      m_perf2;
  logic [5:0]  e_stall;
  logic        e_flush, e_ack, e_done;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CW), .FLUSH_LEN(FL)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id),
    .ex_mc_start(ex_mc_start),
    .ex_mc_cycles(ex_mc_cycles),
    .stallreq_mem(stallreq_mem),
    .excp_req(excp_req),
    .excp_vector(excp_vector),
    .stall(stall), .flush(flush),
    .new_pc(new_pc), .excp_ack(excp_ack),
    .mc_done(mc_done), .perf_stall(perf_stall)
  );

  pipe_ctrl #(
    .CNT_W(CW), .FLUSH_LEN(FL),
    .PERF_RST(32'hFFFF_FFFE)
  ) dut_sat (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id),
    .ex_mc_start(ex_mc_start),
    .ex_mc_cycles(ex_mc_cycles),
    .stallreq_mem(stallreq_mem),
    .excp_req(excp_req),
    .excp_vector(excp_vector),
    .stall(stall2), .flush(flush2),
    .new_pc(new_pc2), .excp_ack(excp_ack2),
    .mc_done(mc_done2), .perf_stall(perf_stall2)
  );

  // Reference: busy = remaining extra EX cycles,
  // fl_left = remaining flush cycles.
  function automatic void model_eval();
    e_stall = 6'b0;
    e_flush = 1'b0;
    e_ack   = 1'b0;
    e_done  = 1'b0;
    if (!rst) begin
      if (fl_left > 0) begin
        e_flush = 1'b1;
      end else begin
        e_ack = excp_req;
        if (busy > 0) begin
          e_stall = 6'b001111;
          e_done  = (busy == 1) && !stallreq_mem
                  && !excp_req;
        end
        if (stallreq_id)  e_stall = e_stall | 6'b000111;
        if (stallreq_mem) e_stall = e_stall | 6'b011111;
      end
    end
  endfunction

  function automatic void model_update();
    model_eval();
    if (rst) begin
      busy    = 0;
      fl_left = 0;
      m_pc    = 32'h0;
      m_perf  = 0;
      m_perf2 = 64'hFFFF_FFFE;
    end else begin
      if (e_stall[0]) begin
        if (m_perf  < 64'hFFFF_FFFF) m_perf++;
        if (m_perf2 < 64'hFFFF_FFFF) m_perf2++;
      end
      if (fl_left > 0) begin
        fl_left--;
      end else if (excp_req) begin
        fl_left = FL;
        m_pc    = excp_vector;
        busy    = 0;
      end else if (busy > 0) begin
        if (!stallreq_mem) busy--;
      end else if (ex_mc_start && ex_mc_cycles != 0) begin
        busy = int'(ex_mc_cycles);
      end
    end
  endfunction

  task automatic idle();
    stallreq_id  = 1'b0;
    ex_mc_start  = 1'b0;
    ex_mc_cycles = '0;
    stallreq_mem = 1'b0;
    excp_req     = 1'b0;
    excp_vector  = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      stallreq_id  = 1'($urandom);
      stallreq_mem = 1'($urandom);
      excp_req     = 1'($urandom);
      ex_mc_start  = 1'($urandom);
      ex_mc_cycles = CW'($urandom);
      excp_vector  = $urandom;
      @(negedge clk);
      n_chk++;
      if ({stall, flush, excp_ack, mc_done} !== 9'b0
          || new_pc !== 32'h0 || perf_stall !== 32'h0) begin
        $display("FAIL reset: stall=%b fl=%b ack=%b done=%b pc=%h perf=%h want zeros",
                 stall, flush, excp_ack, mc_done,
                 new_pc, perf_stall);
      end else n_pass++;
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_id_stall();
    stallreq_id = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk++;
      if (stall !== 6'b000111) begin
        $display("FAIL id_stall: stall=%b want 000111",
                 stall);
      end else n_pass++;
      tick();
    end
    idle();
    @(negedge clk);
    n_chk++;
    if (stall !== 6'b0 || perf_stall !== 32'd2) begin
      $display("FAIL id_perf: stall=%b perf=%0d want 0/2",
               stall, perf_stall);
    end else n_pass++;
    tick();
  endtask

  task automatic test_mc();
    ex_mc_start  = 1'b1;
    ex_mc_cycles = CW'(4);
    @(negedge clk);
    n_chk++;
    if (stall !== 6'b0 || mc_done !== 1'b0) begin
      $display("FAIL mc_issue: stall=%b done=%b want 0/0",
               stall, mc_done);
    end else n_pass++;
    tick();
    idle();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (stall !== 6'b001111 || mc_done !== (i == 4)) begin
        $display("FAIL mc_cyc%0d: stall=%b done=%b want 001111/%0d",
                 i, stall, mc_done, (i == 4));
      end else n_pass++;
      tick();
    end
    @(negedge clk);
    n_chk++;
    if (stall !== 6'b0 || mc_done !== 1'b0
        || perf_stall !== m_perf[31:0]) begin
      $display("FAIL mc_end: stall=%b done=%b perf=%0d want 0/0/%0d",
               stall, mc_done, perf_stall, m_perf);
    end else n_pass++;
    tick();
  endtask

  task automatic test_mc_mem();
    ex_mc_start  = 1'b1;
    ex_mc_cycles = CW'(3);
    tick();
    idle();
    stallreq_mem = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk++;
      if (stall !== 6'b011111 || mc_done !== 1'b0) begin
        $display("FAIL mc_mem_hold: stall=%b done=%b want 011111/0",
                 stall, mc_done);
      end else n_pass++;
      tick();
    end
    stallreq_mem = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (stall !== 6'b001111 || mc_done !== (i == 3)) begin
        $display("FAIL mc_mem_rel%0d: stall=%b done=%b want 001111/%0d",
                 i, stall, mc_done, (i == 3));
      end else n_pass++;
      tick();
    end
    @(negedge clk);
    n_chk++;
    if (stall !== 6'b0) begin
      $display("FAIL mc_mem_end: stall=%b want 0", stall);
    end else n_pass++;
    tick();
  endtask

  task automatic test_excp_mc();
    ex_mc_start  = 1'b1;
    ex_mc_cycles = CW'(5);
    tick();
    idle();
    tick();
    excp_req    = 1'b1;
    excp_vector = 32'h0000_0100;
    @(negedge clk);
    n_chk++;
    if (excp_ack !== 1'b1 || mc_done !== 1'b0
        || flush !== 1'b0) begin
      $display("FAIL excp_mc_ack: ack=%b done=%b fl=%b want 1/0/0",
               excp_ack, mc_done, flush);
    end else n_pass++;
    tick();
    idle();
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      n_chk++;
      if (flush !== 1'b1 || new_pc !== 32'h100
          || stall !== 6'b0 || mc_done !== 1'b0) begin
        $display("FAIL excp_mc_flush%0d: fl=%b pc=%h stall=%b done=%b want 1/100/0/0",
                 i, flush, new_pc, stall, mc_done);
      end else n_pass++;
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_chk++;
      if (flush !== 1'b0 || stall !== 6'b0
          || mc_done !== 1'b0) begin
        $display("FAIL excp_mc_after%0d: fl=%b stall=%b done=%b want 0/0/0",
                 i, flush, stall, mc_done);
      end else n_pass++;
      tick();
    end
  endtask

  task automatic test_excp_vs_start();
    logic [31:0] v1;
    logic [31:0] v2;
    v1 = {$urandom_range(1, 32'hFFFF), 16'h0};
    v2 = ~v1;
    excp_req     = 1'b1;
    excp_vector  = v1;
    ex_mc_start  = 1'b1;
    ex_mc_cycles = CW'(7);
    @(negedge clk);
    n_chk++;
    if (excp_ack !== 1'b1 || stall !== 6'b0) begin
      $display("FAIL excp_start_ack: ack=%b stall=%b want 1/0",
               excp_ack, stall);
    end else n_pass++;
    tick();
    idle();
    for (int i = 0; i < FL; i++) begin
      if (i == 0) begin
        excp_req    = 1'b1;
        excp_vector = v2;
      end
      @(negedge clk);
      n_chk++;
      if (excp_ack !== 1'b0 || flush !== 1'b1
          || new_pc !== v1) begin
        $display("FAIL excp_in_flush%0d: ack=%b fl=%b pc=%h want 0/1/%h",
                 i, excp_ack, flush, new_pc, v1);
      end else n_pass++;
      tick();
      idle();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (stall !== 6'b0 || flush !== 1'b0
          || new_pc !== v1) begin
        $display("FAIL no_mc_entry%0d: stall=%b fl=%b pc=%h want 0/0/%h",
                 i, stall, flush, new_pc, v1);
      end else n_pass++;
      tick();
    end
  endtask

  task automatic test_rst_mid_mc();
    ex_mc_start  = 1'b1;
    ex_mc_cycles = CW'(6);
    tick();
    idle();
    tick();
    rst = 1'b1;
    stallreq_mem = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({stall, flush, excp_ack, mc_done} !== 9'b0) begin
      $display("FAIL rst_mc_during: stall=%b fl=%b ack=%b done=%b want 0",
               stall, flush, excp_ack, mc_done);
    end else n_pass++;
    tick();
    rst = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if ({stall, flush, excp_ack, mc_done} !== 9'b0
          || new_pc !== 32'h0 || perf_stall !== 32'h0) begin
        $display("FAIL rst_mc_after%0d: stall=%b fl=%b done=%b pc=%h perf=%h want 0",
                 i, stall, flush, mc_done, new_pc, perf_stall);
      end else n_pass++;
      tick();
    end
  endtask

  task automatic test_saturate();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stallreq_id = 1'b1;
    repeat (3) tick();
    idle();
    @(negedge clk);
    n_chk++;
    if (perf_stall2 !== 32'hFFFF_FFFF
        || perf_stall !== 32'd3) begin
      $display("FAIL perf_sat: sat=%h base=%0d want ffffffff/3",
               perf_stall2, perf_stall);
    end else n_pass++;
    stallreq_mem = 1'b1;
    tick();
    idle();
    @(negedge clk);
    n_chk++;
    if (perf_stall2 !== 32'hFFFF_FFFF
        || perf_stall !== 32'd4) begin
      $display("FAIL perf_hold: sat=%h base=%0d want ffffffff/4",
               perf_stall2, perf_stall);
    end else n_pass++;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      stallreq_id  = ($urandom_range(0, 4) == 0);
      stallreq_mem = ($urandom_range(0, 5) == 0);
      ex_mc_start  = ($urandom_range(0, 6) == 0);
      ex_mc_cycles = CW'($urandom_range(0, 5));
      excp_req     = ($urandom_range(0, 19) == 0);
      excp_vector  = $urandom;
      @(negedge clk);
      model_eval();
      n_chk++;
      if ({stall, flush, excp_ack, mc_done}
            !== {e_stall, e_flush, e_ack, e_done}
          || new_pc !== m_pc
          || perf_stall !== m_perf[31:0]
          || perf_stall2 !== m_perf2[31:0]) begin
        $display("FAIL rand%0d: stall=%b fl=%b ack=%b done=%b pc=%h perf=%h/%h want %b/%b/%b/%b/%h/%h/%h",
                 i, stall, flush, excp_ack, mc_done, new_pc,
                 perf_stall, perf_stall2, e_stall, e_flush,
                 e_ack, e_done, m_pc, m_perf[31:0],
                 m_perf2[31:0]);
      end else n_pass++;
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
  endtask

  initial begin
    busy    = 0;
    fl_left = 0;
    m_pc    = 32'h0;
    m_perf  = 0;
    m_perf2 = 64'hFFFF_FFFE;
    rst     = 1'b1;
    idle();
    test_reset();
    test_id_stall();
    test_mc();
    test_mc_mem();
    test_excp_mc();
    test_excp_vs_start();
    test_rst_mid_mc();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
